aes_ti_host_ctrl: RTL and testbench

Host-side sequencer for the byte-serial, two-share threshold AES encryption core. Accepts one full 128-bit shared plaintext and a 128-bit key from a host through a valid/ready handshake. Streams the bytes and fresh randomness into the core, pulses its start, and waits for done. Collects the 16 ciphertext byte-shares and presents them as two 128-bit shares through a second valid/ready handshake. Shares are never combined inside this block.

---
 rtl/aes_ti_host_ctrl.sv | 175 +++++++++++++++++
 tb/tb_aes_ti_host_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ti_host_ctrl.sv
// Host-side sequencer for the byte-serial two-share threshold AES core.
// Loads one shared plaintext and key, runs the core, and returns both ciphertext shares.
module aes_ti_host_ctrl #(
   parameter int TIMEOUT_CYCLES = 300
) (
   input  logic         ClkxCI,
   input  logic         RstxSI,
   input  logic         InValidxSI,
   output logic         InReadyxSO,
   input  logic [127:0] PT0xDI,
   input  logic [127:0] PT1xDI,
   input  logic [127:0] KxDI,
   input  logic [15:0]  RandxDI,
   output logic         OutValidxSO,
   input  logic         OutReadyxSI,
   output logic [127:0] C0xDO,
   output logic [127:0] C1xDO,
   output logic         BusyxSO,
   output logic         ErrorxSO,
   output logic         CoreStartxSO,
   output logic [7:0]   CorePT0xDO,
   output logic [7:0]   CorePT1xDO,
   output logic [7:0]   CoreR0xDO,
   output logic [7:0]   CoreR1xDO,
   output logic [7:0]   CoreKxDO,
   input  logic [7:0]   CoreC0xDI,
   input  logic [7:0]   CoreC1xDI,
   input  logic         CoreDonexSI
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      stIdle,
      stLoad,
      stWait,
      stUnload,
      stOut
   } stateT;

   stateT          state;
   stateT          nextState;
   logic [3:0]     byteCnt;
   logic [TW-1:0]  waitCnt;
   logic [127:0]   pt0Reg;
   logic [127:0]   pt1Reg;
   logic [127:0]   kReg;
   logic [127:0]   c0Reg;
   logic [127:0]   c1Reg;
   logic           errorReg;
   logic           timeoutHit;

   // A done arriving on the last allowed wait cycle still wins over the timeout.
   assign timeoutHit = (state == stWait) && !CoreDonexSI &&
                       (waitCnt == TW'(TIMEOUT_CYCLES - 1));

   // State register.
   always_ff @(posedge ClkxCI) begin
      if (RstxSI) begin
         state <= stIdle;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic.
   always_comb begin
      nextState = state;
      case (state)
         stIdle:   if (InValidxSI) nextState = stLoad;
         stLoad:   if (byteCnt == 4'd15) nextState = stWait;
         stWait: begin
            if (CoreDonexSI) begin
               nextState = stUnload;
            end else if (timeoutHit) begin
               nextState = stIdle;
            end
         end
         stUnload: if (byteCnt == 4'd15) nextState = stOut;
         stOut:    if (OutReadyxSI) nextState = stIdle;
         default:  nextState = stIdle;
      endcase
   end

   // Datapath. Input registers shift out MSB-first with zero fill, so after the
   // sixteenth load byte the plaintext shares and key are already wiped.
   // Ciphertext shares shift in at the LSB end, leaving byte 0 on top when full.
   always_ff @(posedge ClkxCI) begin
      if (RstxSI) begin
         byteCnt  <= '0;
         waitCnt  <= '0;
         pt0Reg   <= '0;
         pt1Reg   <= '0;
         kReg     <= '0;
         c0Reg    <= '0;
         c1Reg    <= '0;
         errorReg <= 1'b0;
      end else begin
         case (state)
            stIdle: begin
               byteCnt <= '0;
               if (InValidxSI) begin
                  pt0Reg <= PT0xDI;
                  pt1Reg <= PT1xDI;
                  kReg   <= KxDI;
               end
            end
            stLoad: begin
               pt0Reg  <= {pt0Reg[119:0], 8'h00};
               pt1Reg  <= {pt1Reg[119:0], 8'h00};
               kReg    <= {kReg[119:0], 8'h00};
               byteCnt <= byteCnt + 4'd1;
               waitCnt <= '0;
            end
            stWait: begin
               waitCnt <= waitCnt + TW'(1);
               if (CoreDonexSI) begin
                  c0Reg   <= {c0Reg[119:0], CoreC0xDI};
                  c1Reg   <= {c1Reg[119:0], CoreC1xDI};
                  byteCnt <= 4'd1;
               end else if (timeoutHit) begin
                  errorReg <= 1'b1;
               end
            end
            stUnload: begin
               c0Reg   <= {c0Reg[119:0], CoreC0xDI};
               c1Reg   <= {c1Reg[119:0], CoreC1xDI};
               byteCnt <= byteCnt + 4'd1;
            end
            stOut: begin
               if (OutReadyxSI) begin
                  c0Reg <= '0;
                  c1Reg <= '0;
               end
            end
            default: begin
               byteCnt <= '0;
            end
         endcase
      end
   end

   // Output decode; core-facing data is forced to zero outside LOAD.
   always_comb begin
      InReadyxSO   = 1'b0;
      OutValidxSO  = 1'b0;
      BusyxSO      = (state != stIdle);
      CoreStartxSO = 1'b0;
      CorePT0xDO   = 8'h00;
      CorePT1xDO   = 8'h00;
      CoreKxDO     = 8'h00;
      CoreR0xDO    = 8'h00;
      CoreR1xDO    = 8'h00;
      case (state)
         stIdle: InReadyxSO = 1'b1;
         stLoad: begin
            CoreStartxSO = (byteCnt == 4'd0);
            CorePT0xDO   = pt0Reg[127:120];
            CorePT1xDO   = pt1Reg[127:120];
            CoreKxDO     = kReg[127:120];
            CoreR0xDO    = RandxDI[15:8];
            CoreR1xDO    = RandxDI[7:0];
         end
         stOut:  OutValidxSO = 1'b1;
         default: begin
            InReadyxSO = 1'b0;
         end
      endcase
   end

   assign C0xDO    = c0Reg;
   assign C1xDO    = c1Reg;
   assign ErrorxSO = errorReg;

endmodule

// File: tb/tb_aes_ti_host_ctrl.sv
// Bench for aes_ti_host_ctrl: a behavioural core returns shares of the FIPS-197 ciphertext
// only when it received the expected shares; a scoreboard checks every output handshake.
module tb_aes_ti_host_ctrl;

   localparam int TIMEOUT = 300;
   localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_K  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] MASK_A  = {16{8'ha5}};
   localparam logic [127:0] MASK_B  = {16{8'h3c}};
   localparam logic [127:0] MASK_C  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

   logic         clk = 1'b0;
   logic         rst;
   logic         inValid;
   logic         inReady;
   logic [127:0] pt0;
   logic [127:0] pt1;
   logic [127:0] key;
   logic [15:0]  randBits;
   logic         outValid;
   logic         outReady;
   logic [127:0] c0;
   logic [127:0] c1;
   logic         busy;
   logic         error;
   logic         coreStart;
   logic [7:0]   corePt0;
   logic [7:0]   corePt1;
   logic [7:0]   coreR0;
   logic [7:0]   coreR1;
   logic [7:0]   coreK;
   logic [7:0]   coreC0;
   logic [7:0]   coreC1;
   logic         modelDone;
   logic         spurDone;
   logic         coreDone;

   assign coreDone = modelDone | spurDone;

   aes_ti_host_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .ClkxCI(clk), .RstxSI(rst),
      .InValidxSI(inValid), .InReadyxSO(inReady),
      .PT0xDI(pt0), .PT1xDI(pt1), .KxDI(key), .RandxDI(randBits),
      .OutValidxSO(outValid), .OutReadyxSI(outReady),
      .C0xDO(c0), .C1xDO(c1), .BusyxSO(busy), .ErrorxSO(error),
      .CoreStartxSO(coreStart), .CorePT0xDO(corePt0), .CorePT1xDO(corePt1),
      .CoreR0xDO(coreR0), .CoreR1xDO(coreR1), .CoreKxDO(coreK),
      .CoreC0xDI(coreC0), .CoreC1xDI(coreC1), .CoreDonexSI(coreDone)
   );

   typedef struct packed {
      logic [127:0] c0;
      logic [127:0] c1;
   } expT;

   expT          sbQueue[$];
   int           nVectors = 0;
   int           nMiscompares = 0;
   int           cycle = 0;
   int           acceptCycle = 0;
   bit           latencyPending = 0;
   bit           zeroPending = 0;
   logic [127:0] curPt0, curPt1, curK, curCMask;
   bit           coreMute = 0;
   int           doneDelay = 5;
   int           loadIdx = -1;
   int           waitCnt = -1;
   int           unloadIdx = -1;
   int           startLen = 0;
   int           startCount = 0;
   int           loadEndCycle = 0;
   bit           zeroCheck = 0;
   logic [127:0] capPt0, capPt1, capK, outC0, outC1;

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cycle++;
   end
   initial forever begin
      @(posedge clk);
      #1 randBits = 16'($urandom);
   end
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkVec(input string name, input logic [255:0] act, input logic [255:0] exp);
      nVectors++;
      if (act !== exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Behavioural core: records the streamed bytes and answers with ciphertext shares.
   initial begin
      modelDone = 1'b0;
      coreC0 = 8'h00;
      coreC1 = 8'h00;
      forever begin
         @(posedge clk);
         #2;
         modelDone = 1'b0;
         coreC0 = 8'h00;
         coreC1 = 8'h00;
         if (rst) begin
            loadIdx = -1; waitCnt = -1; unloadIdx = -1; zeroCheck = 0; startLen = 0;
         end else begin
            if (zeroCheck) begin
               checkVec("zeroize_pt", {dut.pt0Reg, dut.pt1Reg}, 256'h0);
               checkVec("zeroize_key", {128'h0, dut.kReg}, 256'h0);
               zeroCheck = 0;
            end
            if (coreStart) begin
               startLen++;
               startCount++;
               loadIdx = 0; waitCnt = -1; unloadIdx = -1;
            end else if (startLen != 0) begin
               checkVec("start_pulse_width", 256'(startLen), 256'(1));
               startLen = 0;
            end
            if (loadIdx >= 0) begin
               capPt0[127-8*loadIdx -: 8] = corePt0;
               capPt1[127-8*loadIdx -: 8] = corePt1;
               capK[127-8*loadIdx -: 8] = coreK;
               checkVec("core_key_byte", 256'(coreK), 256'(8'(loadIdx)));
               checkVec("core_rand", 256'({coreR0, coreR1}), 256'(randBits));
               if (loadIdx == 15) begin
                  loadIdx = -1; waitCnt = 0; loadEndCycle = cycle + 1; zeroCheck = 1;
               end else begin
                  loadIdx++;
               end
            end else if (waitCnt >= 0) begin
               waitCnt++;
               if (!coreMute && waitCnt == doneDelay) begin
                  if (capPt0 == curPt0 && capPt1 == curPt1 && capK == curK &&
                      (curPt0 ^ curPt1) == FIPS_PT && curK == FIPS_K) begin
                     outC0 = curCMask;
                     outC1 = FIPS_CT ^ curCMask;
                  end else begin
                     outC0 = '0;
                     outC1 = '0;
                  end
                  modelDone = 1'b1;
                  coreC0 = outC0[127:120];
                  coreC1 = outC1[127:120];
                  unloadIdx = 1; waitCnt = -1;
               end
            end else if (unloadIdx >= 1) begin
               coreC0 = outC0[127-8*unloadIdx -: 8];
               coreC1 = outC1[127-8*unloadIdx -: 8];
               unloadIdx++;
               if (unloadIdx == 16) unloadIdx = -1;
            end
         end
      end
   end

   // Scoreboard monitor: pops an expectation on every output handshake.
   initial begin
      expT e;
      forever begin
         @(posedge clk);
         #2;
         if (rst) begin
            zeroPending = 0;
            continue;
         end
         if (zeroPending) begin
            checkVec("out_zeroize", {c0, c1}, 256'h0);
            zeroPending = 0;
         end
         if (outValid && latencyPending) begin
            checkVec("latency", 256'(cycle - acceptCycle), 256'(32 + doneDelay));
            latencyPending = 0;
         end
         if (outValid && outReady) begin
            if (sbQueue.size() == 0) begin
               nVectors++;
               nMiscompares++;
               $display("[TB] FAIL unexpected_output: got %h, expected no output", {c0, c1});
            end else begin
               e = sbQueue.pop_front();
               checkVec("cipher_shares", {c0, c1}, e);
               checkVec("cipher_xor", 256'(c0 ^ c1), 256'(FIPS_CT));
            end
            zeroPending = 1;
         end
      end
   end

   task automatic applyStimulus(input logic [127:0] p0, input logic [127:0] p1,
                                input logic [127:0] k, input logic [127:0] cmask,
                                input bit expectOut);
      bit accepted = 0;
      curPt0 = p0; curPt1 = p1; curK = k; curCMask = cmask;
      inValid = 1'b1; pt0 = p0; pt1 = p1; key = k;
      for (int i = 0; i < 200; i++) begin
         if (inReady) begin
            accepted = 1;
            break;
         end
         tick();
      end
      if (!accepted) begin
         checkVec("accept_wait", 256'(0), 256'(1));
      end else begin
         acceptCycle = cycle;
         latencyPending = 1;
         if (expectOut) sbQueue.push_back({cmask, FIPS_CT ^ cmask});
      end
      tick();
      inValid = 1'b0; pt0 = '0; pt1 = '0; key = '0;
   endtask

   task automatic waitDone(input string name);
      bit done = 0;
      for (int i = 0; i < 1000; i++) begin
         if (sbQueue.size() == 0 && !busy) begin
            done = 1;
            break;
         end
         tick();
      end
      if (!done) checkVec({name, "_complete"}, 256'(0), 256'(1));
      tick();
      tick();
   endtask

   task automatic checkOutput(input string name, input logic expError);
      checkVec({name, "_flags"},
               256'({inReady, busy, error, outValid, coreStart, corePt0, corePt1, coreR0, coreR1, coreK}),
               256'({1'b1, 1'b0, expError, 1'b0, 1'b0, 40'h0}));
      checkVec({name, "_cout"}, {c0, c1}, 256'h0);
   endtask

   task automatic applyReset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      latencyPending = 0;
      tick();
   endtask

   initial begin
      logic [127:0] s0, s1;
      bit seen, stable, readyLow;
      int startsBefore;
      rst = 1'b1; inValid = 1'b0; pt0 = '0; pt1 = '0; key = '0;
      outReady = 1'b1; spurDone = 1'b0;
      tick(); tick();
      applyReset();
      checkOutput("reset", 1'b0);

      // Plain FIPS-197 run.
      applyStimulus(MASK_A, MASK_A ^ FIPS_PT, FIPS_K, 128'h0123456789abcdeffedcba9876543210, 1);
      waitDone("fips_a");

      // Reset while the eighth load byte is on the core bus.
      applyStimulus(MASK_B, MASK_B ^ FIPS_PT, FIPS_K, 128'h0, 0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy && coreK == 8'h07) begin
            seen = 1;
            break;
         end
         tick();
      end
      checkVec("midload_reach_byte7", 256'(seen), 256'(1));
      rst = 1'b1;
      tick();
      checkOutput("midload_reset", 1'b0);
      rst = 1'b0;
      latencyPending = 0;
      tick();
      applyStimulus(MASK_B, MASK_B ^ FIPS_PT, FIPS_K, 128'hdeadbeefcafef00d0badc0de13579bdf, 1);
      waitDone("after_reset");

      // Core that never finishes.
      coreMute = 1;
      applyStimulus(MASK_C, MASK_C ^ FIPS_PT, FIPS_K, 128'h0, 0);
      seen = 0;
      stable = 1;
      for (int i = 0; i < TIMEOUT + 100; i++) begin
         if (outValid) stable = 0;
         if (error) begin
            seen = 1;
            break;
         end
         tick();
      end
      checkVec("timeout_seen", 256'(seen), 256'(1));
      checkVec("timeout_cycles", 256'(cycle), 256'(loadEndCycle + TIMEOUT));
      checkVec("timeout_no_valid", 256'(stable), 256'(1));
      checkVec("timeout_idle", 256'({busy, inReady, outValid}), 256'(3'b010));
      latencyPending = 0;
      coreMute = 0;
      tick();
      applyStimulus(MASK_A, MASK_A ^ FIPS_PT, FIPS_K, 128'h5555aaaa5555aaaa0000ffff0000ffff, 1);
      waitDone("after_timeout");
      checkVec("error_sticky", 256'(error), 256'(1));
      applyReset();
      checkOutput("error_cleared", 1'b0);

      // Output backpressure with ignored request pulses.
      outReady = 1'b0;
      applyStimulus(MASK_C, MASK_C ^ FIPS_PT, FIPS_K, 128'h13579bdf2468ace0fedcba0123456789, 1);
      seen = 0;
      for (int i = 0; i < 400; i++) begin
         if (outValid) begin
            seen = 1;
            break;
         end
         tick();
      end
      checkVec("stall_valid_seen", 256'(seen), 256'(1));
      s0 = c0; s1 = c1;
      stable = 1; readyLow = 1;
      startsBefore = startCount;
      for (int i = 0; i < 50; i++) begin
         inValid = i[0];
         pt0 = {4{32'($urandom)}};
         tick();
         if (c0 !== s0 || c1 !== s1 || !outValid) stable = 0;
         if (inReady) readyLow = 0;
      end
      inValid = 1'b0;
      pt0 = '0;
      checkVec("stall_stable", 256'(stable), 256'(1));
      checkVec("stall_inready_low", 256'(readyLow), 256'(1));
      checkVec("stall_no_start", 256'(startCount), 256'(startsBefore));
      outReady = 1'b1;
      waitDone("stall");
      tick(); tick(); tick();
      checkVec("stall_no_queued_req", 256'({busy, inReady}), 256'(2'b01));

      // Spurious done pulses in IDLE, LOAD and UNLOAD.
      spurDone = 1'b1;
      tick();
      spurDone = 1'b0;
      checkVec("spur_idle", 256'({busy, inReady}), 256'(2'b01));
      applyStimulus(MASK_B, MASK_B ^ FIPS_PT, FIPS_K, 128'h8badf00d8badf00d1122334455667788, 1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy && coreK == 8'h03) begin
            seen = 1;
            break;
         end
         tick();
      end
      spurDone = 1'b1;
      tick();
      spurDone = 1'b0;
      checkVec("spur_load", 256'({seen, busy, coreK}), 256'({2'b11, 8'h04}));
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         if (unloadIdx == 8) begin
            seen = 1;
            break;
         end
         tick();
      end
      spurDone = 1'b1;
      tick();
      spurDone = 1'b0;
      checkVec("spur_unload", 256'({seen, busy, outValid}), 256'(3'b110));
      waitDone("spurious");

      tick(); tick();
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
